// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: controller <-> datapath bundle for the multicycle MIPS main controller
// master (controller): inputs op, funct, mem_ready, md_done; outputs every datapath control, illegal_op, state
// slave  (datapath):   the mirror image of master
interface mc_ctrl_fsm_if #(
    parameter int STATE_W = 4,
    parameter int ALUOP_W = 3
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               mem_ready;
    logic               md_done;
    logic               memtoreg;
    logic               memread;
    logic               memwrite;
    logic               regdst;
    logic               regwrite;
    logic               alusrca;
    logic               signext;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic [ALUOP_W-1:0] aluop;
    logic               pcwrite;
    logic               pcwritecond;
    logic               branch_ne;
    logic               iord;
    logic               irwrite;
    logic               md_start;
    logic [1:0]         md_op;
    logic               hilo_write;
    logic               illegal_op;
    logic [STATE_W-1:0] state;
    modport master (
        input  op, funct, mem_ready, md_done,
        output memtoreg, memread, memwrite, regdst, regwrite, alusrca, signext,
               alusrcb, pcsrc, aluop, pcwrite, pcwritecond, branch_ne, iord,
               irwrite, md_start, md_op, hilo_write, illegal_op, state
    );
    modport slave (
        output op, funct, mem_ready, md_done,
        input  memtoreg, memread, memwrite, regdst, regwrite, alusrca, signext,
               alusrcb, pcsrc, aluop, pcwrite, pcwritecond, branch_ne, iord,
               irwrite, md_start, md_op, hilo_write, illegal_op, state
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS main controller with memory wait states, mul/div sequencing and illegal-opcode trap
// Ports: clk (rising edge), reset_n (async, active-low), bus (mc_ctrl_fsm_if.master: op/funct/mem_ready/md_done in,
// datapath enables, mux selects, aluop, md_start/md_op/hilo_write, illegal_op and state out).
// Outputs are a Moore decode of state_q (plus op/funct/mem_ready), so reset forces them all to zero immediately.
// Optional feature: define MC_CTRL_MULDIV_EN to enable the MDSTART/MDWAIT multiply/divide sequence.
module mc_ctrl_fsm #(
    parameter int STATE_W       = 4,
    parameter int ALUOP_W       = 3,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input logic            clk,
    input logic            reset_n,
    mc_ctrl_fsm_if.master  bus
);
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        LWMEM   = 4'd4,
        LWWB    = 4'd5,
        SWMEM   = 4'd6,
        REXEC   = 4'd7,
        RWB     = 4'd8,
        BRANCH  = 4'd9,
        IEXEC   = 4'd10,
        IWB     = 4'd11,
        JUMP    = 4'd12,
        MDSTART = 4'd13,
        MDWAIT  = 4'd14,
        ILLEGAL = 4'd15
    } state_t;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

`ifdef MC_CTRL_MULDIV_EN
    localparam state_t MD_ENTRY = MDSTART;
`else
    localparam state_t MD_ENTRY = ILLEGAL;
    logic unused_md;
    assign unused_md = ^{bus.md_done, bus.funct[1:0]};
`endif

    state_t     state_q;
    state_t     state_d;
    state_t     dec_next;
    logic       rdy;
    logic       r_md;
    logic [2:0] aluop;
    logic [2:0] imm_aluop;
    logic       imm_sext;

    assign rdy       = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
    assign r_md      = bus.funct[5:2] == 4'b0110;
    assign imm_aluop = (bus.op == OP_ANDI)  ? 3'd3 :
                       (bus.op == OP_ORI)   ? 3'd4 :
                       (bus.op == OP_SLTI)  ? 3'd5 :
                       (bus.op == OP_SLTIU) ? 3'd6 : 3'd0;
    // andi/ori zero-extend their immediate; every other I-type sign-extends
    assign imm_sext  = !(bus.op == OP_ANDI || bus.op == OP_ORI);
    assign bus.aluop = ALUOP_W'(aluop);
    assign bus.state = STATE_W'(state_q);

    always_comb begin
        case (bus.op)
            OP_LW, OP_SW:   dec_next = MEMADR;
            OP_R:           dec_next = r_md ? MD_ENTRY : REXEC;
            OP_BEQ, OP_BNE: dec_next = BRANCH;
            OP_J:           dec_next = JUMP;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: dec_next = IEXEC;
            default:        dec_next = ILLEGAL;
        endcase
    end

    always_comb begin
        bus.memtoreg    = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.regdst      = 1'b0;
        bus.regwrite    = 1'b0;
        bus.alusrca     = 1'b0;
        bus.signext     = 1'b0;
        bus.alusrcb     = 2'b00;
        bus.pcsrc       = 2'b00;
        bus.pcwrite     = 1'b0;
        bus.pcwritecond = 1'b0;
        bus.branch_ne   = 1'b0;
        bus.iord        = 1'b0;
        bus.irwrite     = 1'b0;
        bus.md_start    = 1'b0;
        bus.md_op       = 2'b00;
        bus.hilo_write  = 1'b0;
        bus.illegal_op  = 1'b0;
        aluop           = 3'd0;
        state_d         = state_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                bus.memread = 1'b1;
                bus.alusrcb = 2'b01;
                // IR and PC only latch on the cycle the memory actually delivers
                bus.irwrite = rdy;
                bus.pcwrite = rdy;
                state_d     = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alusrcb = 2'b11;
                state_d     = dec_next;
            end
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                bus.signext = 1'b1;
                state_d     = (bus.op == OP_LW) ? LWMEM : SWMEM;
            end
            LWMEM: begin
                bus.iord    = 1'b1;
                bus.memread = 1'b1;
                state_d     = rdy ? LWWB : LWMEM;
            end
            LWWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
                state_d      = FETCH;
            end
            SWMEM: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                state_d      = rdy ? FETCH : SWMEM;
            end
            REXEC: begin
                bus.alusrca = 1'b1;
                aluop       = 3'd2;
                state_d     = RWB;
            end
            RWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
                state_d      = FETCH;
            end
            BRANCH: begin
                bus.alusrca     = 1'b1;
                aluop           = 3'd1;
                bus.pcwritecond = 1'b1;
                bus.pcsrc       = 2'b01;
                bus.branch_ne   = bus.op[0];
                state_d         = FETCH;
            end
            IEXEC: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                bus.signext = imm_sext;
                aluop       = imm_aluop;
                state_d     = IWB;
            end
            IWB: begin
                bus.regwrite = 1'b1;
                bus.alusrca  = 1'b1;
                bus.alusrcb  = 2'b10;
                aluop        = imm_aluop;
                state_d      = FETCH;
            end
            JUMP: begin
                bus.pcwrite = 1'b1;
                bus.pcsrc   = 2'b10;
                state_d     = FETCH;
            end
`ifdef MC_CTRL_MULDIV_EN
            MDSTART: begin
                bus.md_start = 1'b1;
                bus.md_op    = bus.funct[1:0];
                state_d      = MDWAIT;
            end
            MDWAIT: begin
                bus.hilo_write = bus.md_done;
                state_d        = bus.md_done ? FETCH : MDWAIT;
            end
`endif
            ILLEGAL: begin
                bus.illegal_op = 1'b1;
                state_d        = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed plus randomized bench for mc_ctrl_fsm, scored per instruction by latency and strobe counts
module tb_mc_ctrl_fsm;
    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_MD = 3, K_BR = 4, K_J = 5, K_IMM = 6, K_ILL = 7;
`ifdef MC_CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif
    localparam int BASE_LAT [8] = '{5, 4, 4, 4, 3, 3, 4, 3};

    mc_ctrl_fsm_if #(.STATE_W(4), .ALUOP_W(3)) bus();
    mc_ctrl_fsm #(.STATE_W(4), .ALUOP_W(3), .MEM_HANDSHAKE(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] funct);
        if (op == 6'h23) return K_LW;
        if (op == 6'h2b) return K_SW;
        if (op == 6'h00) return (funct[5:2] == 4'b0110) ? (MD_EN ? K_MD : K_ILL) : K_R;
        if (op == 6'h04 || op == 6'h05) return K_BR;
        if (op == 6'h02) return K_J;
        if (op >= 6'h08 && op <= 6'h0d) return K_IMM;
        return K_ILL;
    endfunction

    function automatic int imm_alu(input logic [5:0] op);
        case (op)
            6'h0c:   return 3;
            6'h0d:   return 4;
            6'h0a:   return 5;
            6'h0b:   return 6;
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] outs();
        return 64'({bus.memtoreg, bus.memread, bus.memwrite, bus.regdst, bus.regwrite, bus.alusrca,
                    bus.signext, bus.alusrcb, bus.pcsrc, bus.aluop, bus.pcwrite, bus.pcwritecond,
                    bus.branch_ne, bus.iord, bus.irwrite, bus.md_start, bus.md_op, bus.hilo_write,
                    bus.illegal_op, bus.state});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one instruction starting in FETCH; nf/nm are wait cycles in FETCH and in the data access,
    // mdd the MDWAIT cycles before md_done. Irrelevant handshake inputs are randomized.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input int nf, input int nm, input int mdd);
        int k    = kind_of(op, funct);
        bit mem  = (k == K_LW || k == K_SW);
        int n    = BASE_LAT[k] + nf + (mem ? nm : 0) + (k == K_MD ? mdd : 0);
        int ws   = nf + 3;
        int c_fetch = 0, c_ir = 0, ir_at = -1, c_pcw = 0, c_mr = 0, c_mw = 0, c_rw = 0;
        int c_ill = 0, c_mds = 0, c_hilo = 0, c_pwc = 0, hilo_bad = 0;
        int rw_aluop = -1, br_ne = -1, br_aluop = -1, md_opv = -1, j_pcsrc = -1;
        bus.op    = op;
        bus.funct = funct;
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = (i < nf) ? 1'b0 : (i == nf) ? 1'b1 :
                            (mem && i >= ws && i < ws + nm) ? 1'b0 :
                            (mem && i == ws + nm) ? 1'b1 : 1'($urandom);
            bus.md_done   = (k == K_MD && i >= ws && i < ws + mdd) ? 1'b0 :
                            (k == K_MD && i == ws + mdd) ? 1'b1 : 1'($urandom);
            #1;
            if (bus.state == 4'd1) c_fetch++;
            if (bus.irwrite) begin c_ir++; ir_at = i; end
            if (bus.pcwrite) begin c_pcw++; if (!bus.irwrite) j_pcsrc = int'(bus.pcsrc); end
            c_mr  += int'(bus.memread);
            c_mw  += int'(bus.memwrite);
            c_ill += int'(bus.illegal_op);
            if (bus.regwrite) begin c_rw++; rw_aluop = int'(bus.aluop); end
            if (bus.md_start) begin c_mds++; md_opv = int'(bus.md_op); end
            if (bus.hilo_write) begin c_hilo++; if (!bus.md_done) hilo_bad++; end
            if (bus.pcwritecond) begin c_pwc++; br_ne = int'(bus.branch_ne); br_aluop = int'(bus.aluop); end
            @(posedge clk);
            #1;
        end
        chk("end_state_fetch", bus.state, 1);
        chk("fetch_cycles", c_fetch, nf + 1);
        chk("irwrite_count", c_ir, 1);
        chk("irwrite_cycle", ir_at, nf);
        chk("pcwrite_count", c_pcw, (k == K_J) ? 2 : 1);
        chk("memread_count", c_mr, nf + 1 + ((k == K_LW) ? nm + 1 : 0));
        chk("memwrite_count", c_mw, (k == K_SW) ? nm + 1 : 0);
        chk("regwrite_count", c_rw, (k == K_LW || k == K_R || k == K_IMM) ? 1 : 0);
        chk("illegal_count", c_ill, (k == K_ILL) ? 1 : 0);
        chk("md_start_count", c_mds, (k == K_MD) ? 1 : 0);
        chk("hilo_write_count", c_hilo, (k == K_MD) ? 1 : 0);
        chk("pcwritecond_count", c_pwc, (k == K_BR) ? 1 : 0);
        if (k == K_BR) begin
            chk("branch_ne", br_ne, int'(op[0]));
            chk("branch_aluop", br_aluop, 1);
        end
        if (k == K_IMM) chk("imm_aluop", rw_aluop, imm_alu(op));
        if (k == K_J) chk("jump_pcsrc", j_pcsrc, 2);
        if (k == K_MD) begin
            chk("md_op", md_opv, int'(funct[1:0]));
            chk("hilo_without_done", hilo_bad, 0);
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int         sel;
        reset_n       = 1'b0;
        bus.op        = 6'h00;
        bus.funct     = 6'h00;
        bus.mem_ready = 1'b0;
        bus.md_done   = 1'b0;
        #12;
        chk("reset_outputs", outs(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_to_fetch", bus.state, 1);
        run_instr(6'h23, 6'h00, 2, 1, 0);
        run_instr(6'h2b, 6'h00, 0, 3, 0);
        run_instr(6'h05, 6'h00, 0, 0, 0);
        run_instr(6'h04, 6'h00, 1, 0, 0);
        run_instr(6'h3f, 6'h00, 0, 0, 0);
        run_instr(6'h00, 6'b011010, 0, 0, 5);
        run_instr(6'h00, 6'h20, 1, 0, 0);
        run_instr(6'h02, 6'h00, 0, 0, 0);
        run_instr(6'h0d, 6'h00, 0, 0, 0);
        run_instr(6'h0a, 6'h00, 2, 0, 0);
        bus.op        = 6'h23;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("in_lwmem", bus.state, 4);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_state", bus.state, 0);
        chk("async_reset_outputs", outs(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_fetch", bus.state, 1);
        for (int r = 0; r < 150; r++) begin
            sel = int'($urandom_range(0, 9));
            fn  = 6'($urandom);
            case (sel)
                0:       op = 6'h23;
                1:       op = 6'h2b;
                2:       op = 6'h00;
                3:       begin op = 6'h00; fn = {4'b0110, 2'($urandom)}; end
                4:       op = 6'h04 | 6'($urandom_range(0, 1));
                5:       op = 6'h02;
                6, 7:    op = 6'($urandom_range(8, 13));
                default: op = 6'($urandom);
            endcase
            run_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

- Parametrised multicycle MIPS main controller driving the shared-memory datapath: PC, IR, register file, ALU and ALUOut.
- Adds memory wait-state handshaking, a multi-cycle multiply/divide sequence and illegal-opcode trapping.
- Drives every datapath enable, mux select and ALU opcode as a Moore decode of a posedge state register.

## Interface
- STATE_W, 4, state register width; must be ≥4, upper bits zero.
- ALUOP_W, 3, aluop width; must be ≥3, upper bits zero.
- MEM_HANDSHAKE, 1, 1: honour mem_ready; 0: mem_ready treated as constant 1.
- clk in 1: single clock, rising edge.
- reset_n in 1: asynchronous, active-low reset.
- op in 6: IR[31:26].
- funct in 6: IR[5:0].
- mem_ready in 1: memory access completes this cycle.
- md_done in 1: mul/div unit result valid.
- memtoreg, memread, memwrite, regdst, regwrite, alusrca, signext out 1: datapath controls.
- alusrcb out 2: 00 reg B, 01 const 4, 10 imm, 11 imm<<2.
- pcsrc out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- aluop out ALUOP_W: 0 add, 1 sub, 2 funct, 3 and, 4 or, 5 slt, 6 sltu.
- pcwrite, pcwritecond, branch_ne, iord, irwrite out 1: PC and IR controls.
- md_start out 1; md_op out 2 = funct[1:0]; hilo_write out 1.
- illegal_op out 1.
- state out STATE_W.

## Operation
Outputs are combinational from state, op and mem_ready; unlisted outputs are 0.
- IDLE(0): all 0. Next FETCH.
- FETCH(1): memread, alusrcb=01, aluop=add; irwrite and pcwrite only while mem_ready. Next DECODE on mem_ready, else hold.
- DECODE(2): alusrcb=11, aluop=add. Next by op:
  - lw/sw → MEMADR.
  - R-type → REXEC; mult/multu/div/divu (funct 0110xx) → MDSTART.
  - beq/bne → BRANCH; j → JUMP.
  - addi/addiu/andi/ori/slti/sltiu → IEXEC.
  - any other op → ILLEGAL.
- MEMADR(3): alusrca, alusrcb=10, signext, aluop=add. Next LWMEM if op=lw, else SWMEM.
- LWMEM(4): iord, memread. Hold until mem_ready, then LWWB.
- LWWB(5): memtoreg, regwrite. Next FETCH.
- SWMEM(6): iord, memwrite, held every cycle until mem_ready. Next FETCH.
- REXEC(7): alusrca, aluop=funct. Next RWB.
- RWB(8): regdst, regwrite. Next FETCH.
- BRANCH(9): alusrca, aluop=sub, pcwritecond, pcsrc=01, branch_ne=op[0]. Next FETCH.
- IEXEC(10): alusrca, alusrcb=10. Next IWB.
  - aluop: add for addi/addiu, and for andi, or for ori, slt for slti, sltu for sltiu.
  - signext=1 except andi/ori.
- IWB(11): regwrite; alusrca, alusrcb and aluop as in IEXEC. Next FETCH.
- JUMP(12): pcwrite, pcsrc=10. Next FETCH.
- MDSTART(13): md_start for exactly one cycle; md_op=funct[1:0]. Next MDWAIT.
- MDWAIT(14): hilo_write=md_done. Hold until md_done, then FETCH.
- ILLEGAL(15): illegal_op for exactly one cycle; instruction discarded. Next FETCH.

## Timing
- reset_n low: state=IDLE immediately, independent of clk; all outputs 0.
  - A reset mid-access (LWMEM, SWMEM, MDWAIT) aborts the access with no further writes.
  - First rising edge after release: IDLE→FETCH.
- Instruction latencies with zero wait states, FETCH through last state inclusive:
  - lw 5; sw 4; R-type 4; immediate 4.
  - beq/bne 3; j 3; illegal 3.
  - mul/div 4 + (cycles until md_done).
- Each mem_ready-low cycle adds exactly one cycle in FETCH, LWMEM or SWMEM.
- mem_ready is ignored in all other states.
- md_done seen in MDSTART is ignored; it is honoured only in MDWAIT.
- If md_done and mem_ready are both high, only the one relevant to the current state acts.

## Configuration
- MC_CTRL_MULDIV_EN defined: MDSTART/MDWAIT present as above.
- Undefined:
  - funct 0110xx under op=0 decodes to ILLEGAL.
  - md_start, md_op and hilo_write are tied 0.
  - State codes 13 and 14 are unreachable; md_done is unused.

## Test plan
- reset_n low mid-LWMEM with mem_ready=0: state=0 and all outputs 0 without a clock edge; release → FETCH on next edge.
- lw with mem_ready low 2 cycles in FETCH and 1 in LWMEM:
  - Instruction takes 8 cycles.
  - irwrite/pcwrite high only in the ready FETCH cycle.
  - regwrite high only in LWWB.
- sw with mem_ready low 3 cycles: memwrite high for 4 consecutive cycles, then FETCH.
- bne (op=000101): BRANCH with branch_ne=1, pcwritecond=1, aluop=1; beq gives branch_ne=0.
- op=111111: illegal_op high for exactly one cycle, regwrite/memwrite never asserted, next state FETCH.
- funct=011010 with md_done after 5 cycles:
  - md_start pulses once with md_op=10.
  - hilo_write coincides with md_done.
  - With the macro undefined, the same instruction gives illegal_op.
